// File: rtl/sls_mem_pkg.sv
// sls_mem_pkg -- shared definitions for the memory sweep controller slice.
//   ADDR_W / DATA_W : address and data width of the swept memory (8 bits)
//   state_t         : sweep controller state encoding
//   word_t          : one address or data word
package sls_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Pattern written to / expected at every address of a sweep.
  function automatic word_t pattern(input word_t addr, input word_t seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/sls_mem_chk_v.sv
// sls_mem_chk_v -- read-compare pipeline and error tally.
// The address issued in one cycle is registered with a valid flag; the
// synchronous RAM returns its data one cycle later, when it is compared
// against the expected pattern.
//   Clock, Reset    : clock, synchronous active-high reset
//   clear           : zero the tally (sweep accepted)
//   issue, addr     : read address presented to the RAM this cycle
//   seed            : pattern key of the current sweep
//   mem_dout        : RAM read data for the address issued last cycle
//   err_cnt         : mismatch count, saturating at 255
//   first_err_addr  : address of the first mismatch, 0 if none
module sls_mem_chk_v
  import sls_mem_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       clear,
  input  logic       issue,
  input  logic [7:0] addr,
  input  logic [7:0] seed,
  input  logic [7:0] mem_dout,
  output logic [7:0] err_cnt,
  output logic [7:0] first_err_addr
);

  logic  valid_q;
  word_t addr_q;
  logic  mismatch;

  assign mismatch = valid_q && (mem_dout != pattern(addr_q, seed));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q        <= 1'b0;
      addr_q         <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      valid_q <= issue;
      addr_q  <= addr;
      if (clear) begin
        err_cnt        <= '0;
        first_err_addr <= '0;
      end else if (mismatch) begin
        // A zero tally means this is the first mismatch of the sweep.
        if (err_cnt == 8'd0)   first_err_addr <= addr_q;
        if (err_cnt != 8'hFF)  err_cnt        <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sls_mem_sweep_ctrl_v.sv
// sls_mem_sweep_ctrl_v -- fill / check sweep controller driving an external
// load/count address counter and a synchronous RAM.
//   Clock, Reset             : clock, synchronous active-high reset
//   Start, Mode              : start a sweep (IDLE only); 0 fill, 1 check
//   Base, Len, Seed          : first address, length-1, pattern key
//   Cnt_Q                    : current counter address (= RAM address)
//   Cnt_D, Cnt_LD_EN, Cnt_EN : counter load value / load / count enables
//   Cnt_Reset                : counter reset, follows Reset
//   Mem_WE, Mem_Din          : RAM write enable and write data
//   Mem_Dout                 : RAM read data (one cycle after address)
//   Busy, Done               : not idle / one-cycle end-of-sweep pulse
//   Err_Cnt, First_Err_Addr  : check result, held until the next sweep
module sls_mem_sweep_ctrl_v
  import sls_mem_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Mode,
  input  logic [7:0] Base,
  input  logic [7:0] Len,
  input  logic [7:0] Seed,
  input  logic [7:0] Cnt_Q,
  output logic [7:0] Cnt_D,
  output logic       Cnt_LD_EN,
  output logic       Cnt_EN,
  output logic       Cnt_Reset,
  output logic       Mem_WE,
  output logic [7:0] Mem_Din,
  input  logic [7:0] Mem_Dout,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Err_Cnt,
  output logic [7:0] First_Err_Addr
);

  state_t state_q, state_nx;
  word_t  base_q, len_q, seed_q, rem_q;
  logic   mode_q;
  logic   accept;
  logic   issue;

  assign Cnt_Reset = Reset;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      mode_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_nx;
      if (accept) begin
        base_q <= Base;
        len_q  <= Len;
        seed_q <= Seed;
        mode_q <= Mode;
      end
      if (state_q == S_LOAD) begin
        rem_q <= len_q;
      end else if ((state_q == S_WRITE || state_q == S_READ) && rem_q != 8'd0) begin
        rem_q <= rem_q - 8'd1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_nx  = state_q;
    accept    = 1'b0;
    issue     = 1'b0;
    Cnt_D     = '0;
    Cnt_LD_EN = 1'b0;
    Cnt_EN    = 1'b0;
    Mem_WE    = 1'b0;
    Mem_Din   = '0;
    Done      = 1'b0;
    Busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          accept   = 1'b1;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        Cnt_D     = base_q;
        Cnt_LD_EN = 1'b1;
        state_nx  = mode_q ? S_READ : S_WRITE;
      end
      S_WRITE: begin
        Mem_WE  = 1'b1;
        Mem_Din = pattern(Cnt_Q, seed_q);
        if (rem_q != 8'd0) Cnt_EN   = 1'b1;
        else               state_nx = S_DONE;
      end
      S_READ: begin
        issue = 1'b1;
        if (rem_q != 8'd0) Cnt_EN   = 1'b1;
        else               state_nx = S_DRAIN;
      end
      S_DRAIN: state_nx = S_DONE;   // last read data is compared this cycle
      S_DONE: begin
        Done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // Reset silences the controller in the same cycle it is asserted, so an
    // aborted sweep cannot write, count or pulse Done on its way out.
    if (Reset) begin
      accept    = 1'b0;
      issue     = 1'b0;
      Cnt_D     = '0;
      Cnt_LD_EN = 1'b0;
      Cnt_EN    = 1'b0;
      Mem_WE    = 1'b0;
      Mem_Din   = '0;
      Done      = 1'b0;
      Busy      = 1'b0;
    end
  end

  sls_mem_chk_v u_chk (
    .Clock          (Clock),
    .Reset          (Reset),
    .clear          (accept),
    .issue          (issue),
    .addr           (Cnt_Q),
    .seed           (seed_q),
    .mem_dout       (Mem_Dout),
    .err_cnt        (Err_Cnt),
    .first_err_addr (First_Err_Addr)
  );

endmodule

// File: doc/sls_mem_sweep_ctrl_v.md
SLS_MEM_SWEEP_CTRL_V -- requirements
Module: sls_mem_sweep_ctrl_v

Interface
REQ-001 Clock  in  1  system clock; all state changes on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 Start  in  1  request a sweep; sampled only in IDLE.
REQ-004 Mode  in  1  0 = fill (write), 1 = check (read/compare).
REQ-005 Base  in  8  first address of sweep.
REQ-006 Len  in  8  sweep length minus one; N = Len+1 locations (1..256).
REQ-007 Seed  in  8  data pattern key; expected data = address XOR Seed.
REQ-008 Cnt_Q  in  8  current address from downstream 8-bit load/count address counter.
REQ-009 Cnt_D  out  8  load value to counter.
REQ-010 Cnt_LD_EN  out  1  counter load enable.
REQ-011 Cnt_EN  out  1  counter count enable.
REQ-012 Cnt_Reset  out  1  counter reset; equals Reset combinationally.
REQ-013 Mem_WE  out  1  memory write enable, address = Cnt_Q.
REQ-014 Mem_Din  out  8  memory write data.
REQ-015 Mem_Dout  in  8  memory read data, synchronous RAM, valid one cycle after address.
REQ-016 Busy  out  1  high in every state except IDLE.
REQ-017 Done  out  1  one-cycle pulse at sweep end.
REQ-018 Err_Cnt  out  8  mismatch count, saturating at 255.
REQ-019 First_Err_Addr  out  8  address of first mismatch; 0 if none.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, WRITE, READ, DRAIN, DONE.
REQ-021 IDLE: on Start=1, latch Base/Len/Mode/Seed, clear Err_Cnt and First_Err_Addr, go LOAD; Start outside IDLE SHALL be ignored.
REQ-022 LOAD (1 cycle): Cnt_D=Base, Cnt_LD_EN=1; next state WRITE if Mode=0, else READ; remaining count loaded with Len.
REQ-023 WRITE: Mem_WE=1, Mem_Din=Cnt_Q XOR Seed; if remaining≠0, Cnt_EN=1 and remaining decrements; if remaining=0, Cnt_EN=0 and next state DONE.
REQ-024 READ: address Cnt_Q presented; Cnt_EN and remaining behave as in WRITE; remaining=0 -> DRAIN.
REQ-025 Compare pipeline: address issued in cycle t SHALL be registered with a valid flag and compared at t+1 against Mem_Dout; mismatch -> Err_Cnt+1 (hold at 255), and First_Err_Addr captured on first mismatch only.
REQ-026 DRAIN (1 cycle): performs final compare; next DONE.
REQ-027 DONE (1 cycle): Done=1, Busy=1; next IDLE; Err_Cnt/First_Err_Addr hold until next accepted Start.
REQ-028 Latency: Start sampled at t0; fill Done at t0+N+2; check Done at t0+N+3.
REQ-029 Address wrap 0xFF->0x00 SHALL be permitted; Base+Len beyond 0xFF continues at 0x00.
REQ-030 Cnt_LD_EN and Cnt_EN SHALL never be high in the same cycle; Mem_WE SHALL be 0 outside WRITE.

Reset
REQ-031 Reset SHALL force IDLE, Busy=0, Done=0, Mem_WE=0, Cnt_LD_EN=0, Cnt_EN=0, Cnt_D=0, Mem_Din=0, Err_Cnt=0, First_Err_Addr=0, compare valid=0.
REQ-032 Reset mid-sweep SHALL abort without a Done pulse; Cnt_Reset clears the counter in the same cycle.

Structure
REQ-033 Package sls_mem_pkg SHALL hold the state encoding and address/data width constant (8).
REQ-034 Compare pipeline and error tally SHALL be sub-module sls_mem_chk_v; the counter stays external.

Verification
REQ-035 Fill Base=0x10, Len=3, Seed=0xA5 -> Mem_WE for 4 cycles at 0x10..0x13, data 0xB5,0xB4,0xB7,0xB6; Done at t0+6.
REQ-036 Check same region, intact memory -> Err_Cnt=0, First_Err_Addr=0, Done at t0+7.
REQ-037 Check with 0x12 corrupted, and 0x13 corrupted -> Err_Cnt=2, First_Err_Addr=0x12.
REQ-038 Fill Base=0xFE, Len=3 -> writes 0xFE,0xFF,0x00,0x01; Len=0 -> single write, Done at t0+3.
REQ-039 Check 256 locations with Seed mismatched -> Err_Cnt saturates at 255.
REQ-040 Reset asserted during WRITE, Start pulsed while Busy -> immediate IDLE, no Done; mid-sweep Start ignored.
